// File: rtl/color_decode_pkg.sv
// Shared types and constants for the colour-word decoder.
package color_decode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DIVIDE,
        SCALE,
        DONE
    } state_t;

    typedef logic [2:0] sector_t;

    localparam int LED_BITS  = 8;
    localparam int RED_LSB   = 16;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_LSB  = 0;

    // Pull one 8-bit channel out of a packed {R,G,B} word.
    function automatic logic [LED_BITS-1:0] channelOf(
        input logic [3*LED_BITS-1:0] rgb,
        input int                    lsb
    );
        return rgb[lsb +: LED_BITS];
    endfunction

endpackage

// File: rtl/color_frac_div.sv
// Bit-serial restoring divider producing floor(num * 2^D / den).
// The numerator never exceeds the denominator, so the quotient MSB is
// resolved at load time and the remaining D bits take one cycle each.
module color_frac_div
    import color_decode_pkg::*;
#(
    parameter int D = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [LED_BITS-1:0] num_i,
    input  logic [LED_BITS-1:0] den_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [D:0]          quot_o
);

    localparam int CW = $clog2(D + 1);

    logic [LED_BITS-1:0] remQ;
    logic [LED_BITS-1:0] denQ;
    logic                qHiQ;
    logic [D-1:0]        qLoQ;
    logic [CW-1:0]       countQ;

    logic [LED_BITS:0]   remShift;
    logic                fits;
    logic [LED_BITS-1:0] remD;

    // One restoring step: shift the remainder and subtract the divisor if it fits.
    always_comb begin
        remShift = {remQ, 1'b0};
        fits     = (remShift >= {1'b0, denQ});
        remD     = fits ? LED_BITS'(remShift - {1'b0, denQ}) : remShift[LED_BITS-1:0];
    end

    // Load resolves the top quotient bit; afterwards one lower bit per clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remQ   <= '0;
            denQ   <= '0;
            qHiQ   <= 1'b0;
            qLoQ   <= '0;
            countQ <= '0;
        end else if (load_i) begin
            remQ   <= (num_i >= den_i) ? (num_i - den_i) : num_i;
            denQ   <= den_i;
            qHiQ   <= (num_i >= den_i);
            qLoQ   <= '0;
            countQ <= CW'(D);
        end else if (countQ != '0) begin
            remQ   <= remD;
            qLoQ   <= {qLoQ[D-2:0], fits};
            countQ <= countQ - CW'(1);
        end
    end

    // done_o marks the cycle whose closing edge writes the last quotient bit.
    assign busy_o = (countQ != '0);
    assign done_o = (countQ == CW'(1));
    assign quot_o = {qHiQ, qLoQ};

endmodule

// File: rtl/color_decode.sv
// Recovers note hue and amplitude from a 24-bit LED colour word.
// Sequence: latch colour, classify sector, serial divide, scale to hue.
module color_decode
    import color_decode_pkg::*;
#(
    parameter int D        = 11,
    parameter int HueScale = 683,
    parameter int HueShift = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*LED_BITS-1:0] rgb_i,
    input  logic                  start,
    output logic [D-2:0]          noteHue_o,
    output logic [D-2:0]          noteAmplitude_o,
    output logic                  busy,
    output logic                  data_v
);

    localparam int PW = 2 * D + 2;
    localparam logic [PW-1:0] HUE_MAX = PW'((1 << (D - 1)) - 1);

    state_t                stateQ;
    logic [3*LED_BITS-1:0] rgbQ;
    sector_t               sectorQ;
    logic                  invertQ;
    logic [LED_BITS-1:0]   maxQ;
    logic [D-2:0]          hueQ;
    logic [D-2:0]          ampQ;
    logic                  busyQ;
    logic                  dataVQ;

    logic [LED_BITS-1:0]   red;
    logic [LED_BITS-1:0]   green;
    logic [LED_BITS-1:0]   blue;
    logic [LED_BITS-1:0]   maxCh;
    logic [LED_BITS-1:0]   minCh;
    sector_t               sectorD;
    logic [LED_BITS-1:0]   numD;
    logic [LED_BITS-1:0]   denD;
    logic                  invertD;

    logic                  divBusy;
    logic                  divDone;
    logic [D:0]            divQuot;

    logic [D-1:0]          fracClamped;
    logic [D-1:0]          frac;
    logic [D+2:0]          pos;
    logic [PW-1:0]         prod;
    logic [PW-1:0]         hueWide;
    logic [D-2:0]          hueD;
    logic [D-2:0]          ampD;

    // Classify the latched colour into a hue sixth and its numerator/denominator.
    always_comb begin
        red     = channelOf(rgbQ, RED_LSB);
        green   = channelOf(rgbQ, GREEN_LSB);
        blue    = channelOf(rgbQ, BLUE_LSB);
        maxCh   = red;
        sectorD = 3'd0;
        numD    = '0;
        invertD = 1'b0;
        if (red >= green && red >= blue) begin
            maxCh = red;
            if (green >= blue) begin
                sectorD = 3'd0;
                numD    = green - blue;
            end else begin
                sectorD = 3'd5;
                numD    = blue - green;
                invertD = 1'b1;
            end
        end else if (green >= blue) begin
            maxCh = green;
            if (blue >= red) begin
                sectorD = 3'd2;
                numD    = blue - red;
            end else begin
                sectorD = 3'd1;
                numD    = red - blue;
                invertD = 1'b1;
            end
        end else begin
            maxCh = blue;
            if (red >= green) begin
                sectorD = 3'd4;
                numD    = red - green;
            end else begin
                sectorD = 3'd3;
                numD    = green - red;
                invertD = 1'b1;
            end
        end
        minCh = red;
        if (green < minCh) minCh = green;
        if (blue < minCh)  minCh = blue;
        denD = maxCh - minCh;
        if (denD == '0) begin
            numD    = '0;
            denD    = 8'd1;
            sectorD = 3'd0;
            invertD = 1'b0;
        end
    end

    color_frac_div #(
        .D(D)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .load_i (stateQ == SETUP),
        .num_i  (numD),
        .den_i  (denD),
        .busy_o (divBusy),
        .done_o (divDone),
        .quot_o (divQuot)
    );

    // Turn the finished quotient into a sector position, then scale it to hue.
    always_comb begin
        fracClamped = divQuot[D] ? {D{1'b1}} : divQuot[D-1:0];
        frac        = invertQ ? ({D{1'b1}} - fracClamped) : fracClamped;
        pos         = {sectorQ, frac};
        prod        = PW'(pos) * PW'(HueScale);
        hueWide     = prod >> HueShift;
        hueD        = (hueWide > HUE_MAX) ? HUE_MAX[D-2:0] : hueWide[D-2:0];
        ampD        = (D-1)'(maxQ) << (D - 9);
    end

    // Control sequence with registered busy/data_v and held result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ  <= IDLE;
            rgbQ    <= '0;
            sectorQ <= '0;
            invertQ <= 1'b0;
            maxQ    <= '0;
            hueQ    <= '0;
            ampQ    <= '0;
            busyQ   <= 1'b0;
            dataVQ  <= 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
                    dataVQ <= 1'b0;
                    if (start) begin
                        rgbQ   <= rgb_i;
                        busyQ  <= 1'b1;
                        stateQ <= SETUP;
                    end
                end
                SETUP: begin
                    sectorQ <= sectorD;
                    invertQ <= invertD;
                    maxQ    <= maxCh;
                    stateQ  <= DIVIDE;
                end
                DIVIDE: begin
                    if (divDone || !divBusy) begin
                        stateQ <= SCALE;
                    end
                end
                SCALE: begin
                    hueQ   <= hueD;
                    ampQ   <= ampD;
                    dataVQ <= 1'b1;
                    stateQ <= DONE;
                end
                DONE: begin
                    dataVQ <= 1'b0;
                    busyQ  <= 1'b0;
                    stateQ <= IDLE;
                end
                default: begin
                    dataVQ <= 1'b0;
                    busyQ  <= 1'b0;
                    stateQ <= IDLE;
                end
            endcase
        end
    end

    assign noteHue_o       = hueQ;
    assign noteAmplitude_o = ampQ;
    assign busy            = busyQ;
    assign data_v          = dataVQ;

endmodule

// File: tb/tb_color_decode.sv
// Bench for color_decode: directed colours, randomized colours against a
// reference model, start-while-busy, back-to-back and mid-operation reset.
module tb_color_decode;

    localparam int D       = 11;
    localparam int LATENCY = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic [23:0]  rgbIn;
    logic         start;
    logic [D-2:0] noteHue;
    logic [D-2:0] noteAmp;
    logic         busy;
    logic         dataV;

    int checks = 0;
    int passes = 0;

    color_decode #(
        .D        (D),
        .HueScale (683),
        .HueShift (13)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rgb_i           (rgbIn),
        .start           (start),
        .noteHue_o       (noteHue),
        .noteAmplitude_o (noteAmp),
        .busy            (busy),
        .data_v          (dataV)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference: hue from the hexcone sixth of the colour, amplitude from its peak channel.
    function automatic void refModel(input logic [23:0] c, output int hue, output int amp);
        int r, g, b, mx, mn, sector, num, frac;
        bit inv;
        r = int'(c[23:16]);
        g = int'(c[15:8]);
        b = int'(c[7:0]);
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        amp = mx * (1 << (D - 9));
        sector = 0; num = 0; inv = 0;
        if (mx != mn) begin
            if (r == mx) begin
                if (g >= b) begin sector = 0; num = g - b; end
                else begin sector = 5; num = b - g; inv = 1; end
            end else if (g == mx) begin
                if (b >= r) begin sector = 2; num = b - r; end
                else begin sector = 1; num = r - b; inv = 1; end
            end else begin
                if (r >= g) begin sector = 4; num = r - g; end
                else begin sector = 3; num = g - r; inv = 1; end
            end
        end
        frac = (mx == mn) ? 0 : (num * (1 << D)) / (mx - mn);
        if (frac > (1 << D) - 1) frac = (1 << D) - 1;
        if (inv) frac = (1 << D) - 1 - frac;
        hue = ((sector * (1 << D) + frac) * 683) / 8192;
        if (hue > 1023) hue = 1023;
    endfunction

    // Random channel value biased towards 0, mid and full scale to provoke ties.
    function automatic logic [7:0] randChannel();
        int sel;
        sel = int'($urandom_range(0, 5));
        case (sel)
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Called on a negedge: issue one start, scramble rgb afterwards, wait for data_v.
    task automatic applyStimulus(input logic [23:0] c, output int lat,
                                 output logic [D-2:0] hue, output logic [D-2:0] amp,
                                 output bit busyOk);
        rgbIn  = c;
        start  = 1'b1;
        busyOk = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rgbIn = 24'($urandom);
        lat   = 1;
        while (dataV !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busyOk = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) busyOk = 1'b0;
        hue = noteHue;
        amp = noteAmp;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        rgbIn = '0;
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (noteHue !== '0) $display("[TB] FAIL reset_hue got=%0d want=0", noteHue); else passes++;
        checks++;
        if (noteAmp !== '0) $display("[TB] FAIL reset_amp got=%0d want=0", noteAmp); else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", busy); else passes++;
        checks++;
        if (dataV !== 1'b0) $display("[TB] FAIL reset_data_v got=%b want=0", dataV); else passes++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [23:0] vecs[10] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF8000, 24'hFF00FF,
                                  24'h404040, 24'h000000, 24'h80FF00, 24'hFF0001, 24'h0080FF};
        int expHue[10] = '{0, 341, 683, 85, 853, 0, 0, 255, 1023, 597};
        int expAmp[10] = '{1020, 1020, 1020, 1020, 1020, 256, 0, 1020, 1020, 1020};
        int lat;
        logic [D-2:0] hue, amp;
        bit busyOk;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], lat, hue, amp, busyOk);
            checks++;
            if (lat != LATENCY) $display("[TB] FAIL dir_latency rgb=%06h got=%0d want=%0d", vecs[i], lat, LATENCY); else passes++;
            checks++;
            if (busyOk !== 1'b1) $display("[TB] FAIL dir_busy rgb=%06h busy dropped before data_v, want held", vecs[i]); else passes++;
            checks++;
            if (hue !== (D-1)'(expHue[i])) $display("[TB] FAIL dir_hue rgb=%06h got=%0d want=%0d", vecs[i], hue, expHue[i]); else passes++;
            checks++;
            if (amp !== (D-1)'(expAmp[i])) $display("[TB] FAIL dir_amp rgb=%06h got=%0d want=%0d", vecs[i], amp, expAmp[i]); else passes++;
            @(negedge clk);
            checks++;
            if ({busy, dataV} !== 2'b00) $display("[TB] FAIL dir_idle rgb=%06h got busy,data_v=%b%b want=00", vecs[i], busy, dataV); else passes++;
        end
    endtask

    task automatic test_random();
        int lat, eh, ea;
        logic [D-2:0] hue, amp;
        logic [23:0] c;
        bit busyOk;
        for (int i = 0; i < 24; i++) begin
            c = {randChannel(), randChannel(), randChannel()};
            refModel(c, eh, ea);
            applyStimulus(c, lat, hue, amp, busyOk);
            checks++;
            if (lat != LATENCY) $display("[TB] FAIL rnd_latency rgb=%06h got=%0d want=%0d", c, lat, LATENCY); else passes++;
            checks++;
            if (hue !== (D-1)'(eh)) $display("[TB] FAIL rnd_hue rgb=%06h got=%0d want=%0d", c, hue, eh); else passes++;
            checks++;
            if (amp !== (D-1)'(ea)) $display("[TB] FAIL rnd_amp rgb=%06h got=%0d want=%0d", c, amp, ea); else passes++;
            @(negedge clk);
            checks++;
            if (dataV !== 1'b0) $display("[TB] FAIL rnd_pulse rgb=%06h data_v got=%b want=0", c, dataV); else passes++;
        end
    endtask

    task automatic test_ignore_busy();
        logic [23:0] c1, c2;
        int lat, pulses, eh, ea;
        c1 = 24'hFF8000;
        c2 = 24'h0000FF;
        refModel(c1, eh, ea);
        rgbIn = c1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        repeat (4) begin @(negedge clk); lat++; end
        rgbIn = c2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat++;
        while (dataV !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        checks++;
        if (lat != LATENCY) $display("[TB] FAIL busy_start_latency got=%0d want=%0d", lat, LATENCY); else passes++;
        checks++;
        if (noteHue !== (D-1)'(eh)) $display("[TB] FAIL busy_start_hue got=%0d want=%0d", noteHue, eh); else passes++;
        // start during the data_v cycle must be dropped as well
        rgbIn = c2;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        repeat (30) begin
            if (dataV === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) $display("[TB] FAIL done_start_pulses got=%0d want=0", pulses); else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL done_start_busy got=%b want=0", busy); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, eh, ea;
        logic [D-2:0] hue, amp;
        bit busyOk;
        applyStimulus(24'hFF8000, lat1, hue, amp, busyOk);
        checks++;
        if (hue !== (D-1)'(85)) $display("[TB] FAIL b2b_first_hue got=%0d want=85", hue); else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL b2b_gap_busy got=%b want=0", busy); else passes++;
        refModel(24'h0080FF, eh, ea);
        applyStimulus(24'h0080FF, lat2, hue, amp, busyOk);
        checks++;
        if (lat2 != LATENCY) $display("[TB] FAIL b2b_latency got=%0d want=%0d", lat2, LATENCY); else passes++;
        checks++;
        if (hue !== (D-1)'(eh)) $display("[TB] FAIL b2b_hue got=%0d want=%0d", hue, eh); else passes++;
        checks++;
        if (amp !== (D-1)'(ea)) $display("[TB] FAIL b2b_amp got=%0d want=%0d", amp, ea); else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int lat, pulses;
        logic [D-2:0] hue, amp;
        bit busyOk;
        rgbIn = 24'hFF00FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL midrst_busy got=%b want=0", busy); else passes++;
        checks++;
        if (noteHue !== '0) $display("[TB] FAIL midrst_hue got=%0d want=0", noteHue); else passes++;
        checks++;
        if (noteAmp !== '0) $display("[TB] FAIL midrst_amp got=%0d want=0", noteAmp); else passes++;
        @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
        repeat (30) begin
            if (dataV === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) $display("[TB] FAIL midrst_pulses got=%0d want=0", pulses); else passes++;
        applyStimulus(24'h00FF00, lat, hue, amp, busyOk);
        checks++;
        if (lat != LATENCY) $display("[TB] FAIL postrst_latency got=%0d want=%0d", lat, LATENCY); else passes++;
        checks++;
        if (hue !== (D-1)'(341)) $display("[TB] FAIL postrst_hue got=%0d want=341", hue); else passes++;
        checks++;
        if (amp !== (D-1)'(1020)) $display("[TB] FAIL postrst_amp got=%0d want=1020", amp); else passes++;
        @(negedge clk);
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
